// File: rtl/axis_packet_switch.sv
// Packet-level round-robin switch: NUM_INPUTS AXI-Stream inputs merged onto one registered output.
// Latency: 2 clocks from first sampled TVALID on an idle switch (grant, accept); 1 beat/clock inside a packet.
// Backpressure: only the granted input sees TREADY, and only when the output register is free or draining.
module axis_packet_switch #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_INPUTS = 4,
    localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] AXIS_IN_TDATA,
    input  logic [NUM_INPUTS-1:0]            AXIS_IN_TVALID,
    input  logic [NUM_INPUTS-1:0]            AXIS_IN_TLAST,
    output logic [NUM_INPUTS-1:0]            AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0]            AXIS_OUT_TDATA,
    output logic                             AXIS_OUT_TVALID,
    output logic                             AXIS_OUT_TLAST,
    output logic [SEL_WIDTH-1:0]             AXIS_OUT_TID,
    input  logic                             AXIS_OUT_TREADY
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  last_grant;
    logic [SEL_WIDTH-1:0]  arb_idx;
    logic                  arb_found;
    logic                  out_free;
    logic                  in_hs;
    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    assign out_free = !AXIS_OUT_TVALID || AXIS_OUT_TREADY;
    assign in_hs    = (state == BUSY) && sel_vld && out_free;

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SEL_WIDTH'(i)) begin
                sel_vld  = AXIS_IN_TVALID[i];
                sel_last = AXIS_IN_TLAST[i];
                sel_data = AXIS_IN_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting just after the last packet's owner; only real indices can win.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!arb_found && AXIS_IN_TVALID[i] &&
                    i == (int'(last_grant) + k) % NUM_INPUTS) begin
                    arb_idx   = SEL_WIDTH'(i);
                    arb_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        AXIS_IN_TREADY = '0;
        if (!reset && state == BUSY) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (grant == SEL_WIDTH'(i)) begin
                    AXIS_IN_TREADY[i] = out_free;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            grant           <= '0;
            last_grant      <= SEL_WIDTH'(NUM_INPUTS - 1);
            AXIS_OUT_TVALID <= 1'b0;
            AXIS_OUT_TLAST  <= 1'b0;
            AXIS_OUT_TDATA  <= '0;
            AXIS_OUT_TID    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant <= arb_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // The lock is released only by an accepted TLAST beat, never by a TVALID gap.
                    if (in_hs && sel_last) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase

            if (in_hs) begin
                AXIS_OUT_TVALID <= 1'b1;
                AXIS_OUT_TDATA  <= sel_data;
                AXIS_OUT_TLAST  <= sel_last;
                AXIS_OUT_TID    <= grant;
            end else if (AXIS_OUT_TREADY) begin
                AXIS_OUT_TVALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_switch.sv
// Scoreboarded bench: packet-level round-robin model predicts output order; monitor checks every output beat.
module tb_axis_packet_switch;
    localparam int DW = 16;
    localparam int NI = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
        logic [SW-1:0] tid;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NI*DW-1:0] in_dat;
    logic [NI-1:0]    in_vld;
    logic [NI-1:0]    in_last;
    logic [NI-1:0]    in_rdy;
    logic [DW-1:0]    out_dat;
    logic             out_vld;
    logic             out_last;
    logic [SW-1:0]    out_tid;
    logic             out_rdy;

    logic [23:0]      t3_dat;
    logic [2:0]       t3_vld;
    logic [2:0]       t3_last;
    logic [2:0]       t3_rdy;
    logic [7:0]       t3_odat;
    logic             t3_ovld;
    logic             t3_olast;
    logic [1:0]       t3_otid;
    logic             t3_ordy;

    axis_packet_switch #(.DATA_WIDTH(DW), .NUM_INPUTS(NI)) dut (
        .clk(clk), .reset(reset),
        .AXIS_IN_TDATA(in_dat), .AXIS_IN_TVALID(in_vld), .AXIS_IN_TLAST(in_last),
        .AXIS_IN_TREADY(in_rdy),
        .AXIS_OUT_TDATA(out_dat), .AXIS_OUT_TVALID(out_vld), .AXIS_OUT_TLAST(out_last),
        .AXIS_OUT_TID(out_tid), .AXIS_OUT_TREADY(out_rdy)
    );

    axis_packet_switch #(.DATA_WIDTH(8), .NUM_INPUTS(3)) dut3 (
        .clk(clk), .reset(reset),
        .AXIS_IN_TDATA(t3_dat), .AXIS_IN_TVALID(t3_vld), .AXIS_IN_TLAST(t3_last),
        .AXIS_IN_TREADY(t3_rdy),
        .AXIS_OUT_TDATA(t3_odat), .AXIS_OUT_TVALID(t3_ovld), .AXIS_OUT_TLAST(t3_olast),
        .AXIS_OUT_TID(t3_otid), .AXIS_OUT_TREADY(t3_ordy)
    );

    always #5 clk = ~clk;

    int      total = 0;
    int      bad = 0;
    beat_t   src_q[NI][$];
    beat_t   mq[NI][$];
    exp_t    exp_q[$];
    logic [NI-1:0] hs;
    logic [NI-1:0] mid;
    int      acc[NI];
    int      model_last;
    int      gap_pct;
    int      rdy_pct;
    bit      mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock of the source/sink drivers; returns 1 time unit after the falling edge.
    task automatic step();
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (hs[i]) begin
                b = src_q[i].pop_front();
                mid[i] = !b.last;
            end
        end
        out_rdy = ($urandom_range(99) < rdy_pct);
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0) begin
                in_dat[i*DW +: DW] = src_q[i][0].dat;
                in_last[i] = src_q[i][0].last;
                in_vld[i] = !(mid[i] && ($urandom_range(99) < gap_pct));
            end else begin
                in_vld[i] = 1'b0;
            end
        end
        #1;
        hs = in_vld & in_rdy;
        for (int i = 0; i < NI; i++) if (hs[i]) acc[i]++;
        if (out_vld && !out_rdy) check("stall_in_rdy", 64'(in_rdy), 64'd0);
        if (|mid) check("lock_in_rdy", 64'(in_rdy & ~mid), 64'd0);
    endtask

    task automatic add_pkt(input int i, input int len, input int dat0);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.dat = (dat0 < 0) ? DW'($urandom) : DW'(dat0 + b);
            x.last = (b == len - 1);
            src_q[i].push_back(x);
            mq[i].push_back(x);
        end
    endtask

    // Whole packets leave in round-robin order among inputs that still have packets queued.
    task automatic predict();
        int    pick;
        int    idx;
        beat_t b;
        exp_t  e;
        forever begin
            pick = -1;
            for (int k = 1; k <= NI; k++) begin
                idx = (model_last + k) % NI;
                if (pick < 0 && mq[idx].size() > 0) pick = idx;
            end
            if (pick < 0) break;
            do begin
                b = mq[pick].pop_front();
                e.dat = b.dat;
                e.last = b.last;
                e.tid = SW'(pick);
                exp_q.push_back(e);
            end while (!b.last);
            model_last = pick;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got tid=%0d dat=%0h expected no beat", out_tid, out_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dat", 64'(out_dat), 64'(e.dat));
                    check("out_last", 64'(out_last), 64'(e.last));
                    check("out_tid", 64'(out_tid), 64'(e.tid));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin : main
        int first;
        int lastc;
        int nv;
        int n;
        int target;
        int n3;
        int exp3;

        reset = 1'b1;
        in_dat = '0;
        in_vld = '1;
        in_last = '0;
        out_rdy = 1'b0;
        t3_dat = {8'h22, 8'h11, 8'h00};
        t3_vld = 3'b111;
        t3_last = 3'b111;
        t3_ordy = 1'b1;
        hs = '0;
        mid = '0;
        for (int i = 0; i < NI; i++) acc[i] = 0;
        model_last = NI - 1;
        gap_pct = 0;
        rdy_pct = 100;
        mon_en = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_dat", 64'(out_dat), 64'd0);
        check("rst_out_tid", 64'(out_tid), 64'd0);
        check("rst_t3_rdy", 64'(t3_rdy), 64'd0);
        in_vld = '0;
        t3_vld = '0;
        reset = 1'b0;

        // Four inputs, 3-beat packets, sink always ready: 12 beats with 3 single-cycle bubbles.
        for (int i = 0; i < NI; i++) add_pkt(i, 3, 16'h100 * i);
        predict();
        first = -1;
        lastc = -1;
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_vld) begin
                if (first < 0) first = c;
                lastc = c;
                nv++;
            end
        end
        check("rr_span", 64'(lastc - first + 1), 64'd15);
        check("rr_beats", 64'(nv), 64'd12);
        drain("rr", 50);

        // Single-beat packet on input 2 into an idle switch.
        add_pkt(2, 1, 'hA5);
        predict();
        step();
        step();
        check("lat_grant_vld", 64'(out_vld), 64'd0);
        check("lat_grant_rdy", 64'(in_rdy), 64'b0100);
        step();
        check("lat_out_vld", 64'(out_vld), 64'd1);
        drain("lat", 20);

        // Randomized packets, TVALID gaps mid-packet and downstream stalls.
        gap_pct = 30;
        rdy_pct = 70;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NI; i++) begin
                n = $urandom_range(3);
                for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(5, 1), -1);
            end
            predict();
            drain("rand", 3000);
        end

        // Long stall: sink held off while a 4-beat packet from input 1 is in flight.
        gap_pct = 0;
        rdy_pct = 100;
        add_pkt(1, 4, 'h300);
        predict();
        target = acc[1] + 2;
        n = 0;
        while (acc[1] < target && n < 50) begin
            step();
            n++;
        end
        rdy_pct = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_vld", 64'(out_vld), 64'd1);
            check("stall_hold_dat", 64'(out_dat), 64'h301);
        end
        rdy_pct = 100;
        drain("stall", 50);

        // Reset in the middle of a 5-beat packet, lock previously held by input 0.
        add_pkt(0, 1, -1);
        predict();
        drain("pre_rst", 20);
        add_pkt(1, 5, -1);
        predict();
        target = acc[1] + 2;
        n = 0;
        while (acc[1] < target && n < 50) begin
            step();
            n++;
        end
        check("rst_setup_beats", 64'(acc[1]), 64'(target));
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mid_rdy_comb", 64'(in_rdy), 64'd0);
        @(negedge clk);
        #1;
        check("rst_mid_out_vld", 64'(out_vld), 64'd0);
        check("rst_mid_in_rdy", 64'(in_rdy), 64'd0);
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        hs = '0;
        mid = '0;
        in_vld = '0;
        model_last = NI - 1;
        reset = 1'b0;
        mon_en = 1'b1;
        add_pkt(2, 2, -1);
        add_pkt(1, 2, -1);
        add_pkt(0, 2, -1);
        predict();
        step();
        step();
        check("post_rst_grant", 64'(in_rdy), 64'b0001);
        drain("post_rst", 50);

        // Three-input instance: inputs 0 and 2 always valid must alternate 0,2,0,2.
        @(negedge clk);
        t3_vld = 3'b101;
        n3 = 0;
        exp3 = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (t3_ovld) begin
                check("t3_tid", 64'(t3_otid), 64'(exp3));
                check("t3_dat", 64'(t3_odat), 64'(exp3 * 'h11));
                exp3 = (exp3 == 0) ? 2 : 0;
                n3++;
            end
        end
        check("t3_beats", 64'(n3), 64'd12);
        t3_vld = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_packet_switch.md
AXIS_PACKET_SWITCH -- requirements
Module: axis_packet_switch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512, the per-stream data width in bits.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 4, the number of input streams; legal range 2..8.
REQ-003 The block SHALL have derived localparam SEL_WIDTH = max(1, clog2(NUM_INPUTS)), the width of the input index.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 AXIS_IN_TDATA  input  NUM_INPUTS*DATA_WIDTH  packed input data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 AXIS_IN_TVALID  input  NUM_INPUTS  per-input valid.
REQ-008 AXIS_IN_TLAST  input  NUM_INPUTS  per-input end-of-packet.
REQ-009 AXIS_IN_TREADY  output  NUM_INPUTS  per-input ready.
REQ-010 AXIS_OUT_TDATA  output  DATA_WIDTH  registered output data.
REQ-011 AXIS_OUT_TVALID  output  1  registered output valid.
REQ-012 AXIS_OUT_TLAST  output  1  registered output end-of-packet.
REQ-013 AXIS_OUT_TID  output  SEL_WIDTH  index of the input that sourced the current output beat.
REQ-014 AXIS_OUT_TREADY  input  1  downstream ready.

Function
REQ-015 Arbitration SHALL be per packet via a two-state FSM: IDLE (no grant) and BUSY (locked to input "grant").
REQ-016 In IDLE, with any AXIS_IN_TVALID bit set, the FSM SHALL register grant = first valid index searching upward from (last_grant+1) with wrap modulo NUM_INPUTS, and enter BUSY on the next clock.
REQ-017 In IDLE, all AXIS_IN_TREADY bits SHALL be 0.
REQ-018 In BUSY, AXIS_IN_TREADY[grant] SHALL equal (!AXIS_OUT_TVALID || AXIS_OUT_TREADY), combinationally; all other TREADY bits SHALL be 0.
REQ-019 An input handshake (granted TVALID && TREADY) SHALL load TDATA, TLAST and TID=grant into the output register and set AXIS_OUT_TVALID=1 on the next clock.
REQ-020 Without an input handshake, an output handshake SHALL clear AXIS_OUT_TVALID on the next clock.
REQ-021 While AXIS_OUT_TVALID=1 and AXIS_OUT_TREADY=0, AXIS_OUT_TDATA, TLAST and TID SHALL hold stable.
REQ-022 An accepted input beat with TLAST=1 SHALL return the FSM to IDLE and set last_grant=grant.
REQ-023 The granted input deasserting TVALID mid-packet SHALL NOT release the lock; the FSM SHALL stay in BUSY until its TLAST beat is accepted.
REQ-024 Other inputs SHALL be ignored while BUSY, regardless of their TVALID.
REQ-025 Latency: a beat presented to an idle switch SHALL appear at AXIS_OUT_TVALID two clocks after TVALID is first sampled (grant cycle, accept cycle).
REQ-026 Within a packet, throughput SHALL be one beat per clock while downstream is ready; exactly one idle input cycle SHALL occur between packets.
REQ-027 A pending output beat SHALL continue draining while the FSM is in IDLE.
REQ-028 A single-beat packet (TLAST on first beat) SHALL be legal and SHALL free the arbiter after one accepted beat.
REQ-029 With NUM_INPUTS not a power of two, the wrap from NUM_INPUTS-1 SHALL go to 0; unused index values SHALL never be granted.

Reset
REQ-030 While reset=1 at a clock edge: FSM=IDLE, grant=0, last_grant=NUM_INPUTS-1, AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, AXIS_OUT_TID=0.
REQ-031 While reset=1, AXIS_IN_TREADY SHALL be all 0.
REQ-032 Reset mid-packet SHALL discard the output register contents and the lock; the first post-reset grant SHALL favour input 0.

Verification
REQ-033 All four inputs valid with 3-beat packets, OUT_TREADY=1 -> output TID sequence 0,0,0,1,1,1,2,2,2,3,3,3, TLAST on every 3rd beat, one bubble between packets.
REQ-034 Input 2 only, 1-beat packet, TDATA=0xA5 -> AXIS_OUT_TVALID rises 2 clocks later with TDATA=0xA5, TID=2, TLAST=1.
REQ-035 Input 1 granted, 4-beat packet, OUT_TREADY held 0 for 5 cycles after beat 2 -> TREADY[1]=0 during stall, output holds beat 2, no beat lost or duplicated.
REQ-036 Input 0 drops TVALID for 3 cycles mid-packet while input 3 is valid -> input 3 gets no TREADY until input 0's TLAST is accepted; next grant=3.
REQ-037 Reset asserted on beat 2 of a 5-beat packet -> next clock AXIS_OUT_TVALID=0, all TREADY=0; after release, input 0 (if valid) is granted first.
REQ-038 NUM_INPUTS=3, inputs 0 and 2 continuously valid -> grants alternate 0,2,0,2; index 3 never appears on TID.
